// File: rtl/mmio_gpio_pkg.sv
// mmio_gpio_pkg: shared constants for the memory-mapped GPIO peripheral.
//   - byte offsets of the registers inside the 64-byte window
//   - window size
//   - deb_width(): counter width needed by the input debouncer
// Optional feature macro used by the design: MMIO_GPIO_DEBOUNCE_EN.
package mmio_gpio_pkg;

  localparam logic [5:0] GPIO_IN_OFS      = 6'h00;
  localparam logic [5:0] GPIO_OUT_OFS     = 6'h04;
  localparam logic [5:0] GPIO_OUT_SET_OFS = 6'h08;
  localparam logic [5:0] GPIO_OUT_CLR_OFS = 6'h0C;
  localparam logic [5:0] GPIO_EDGE_OFS    = 6'h10;
  localparam logic [5:0] GPIO_IRQ_EN_OFS  = 6'h14;

  localparam int GPIO_WINDOW_BYTES = 64;

  // Counter counts 0..cycles-1, so $clog2(cycles) bits suffice.
  function automatic int deb_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mmio_gpio_debounce.sv
// gpio_debounce: one GPIO input channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous board input
//   dout       : accepted (stable) input level
//   rise       : high in the cycle before dout goes 0->1, so the parent can
//                set its edge flag on the same clock edge that dout rises
// With MMIO_GPIO_DEBOUNCE_EN defined the channel is a 2-flop synchroniser
// followed by a stability counter; otherwise it is the synchroniser alone
// and CYCLES is only range-checked.
module gpio_debounce
  import mmio_gpio_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  if (CYCLES < 2) begin : g_bad_cycles
    $error("gpio_debounce: CYCLES must be at least 2");
  end

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef MMIO_GPIO_DEBOUNCE_EN
  localparam int CW = deb_width(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stable;
  logic          accept;

  // The counter only runs while the synchronised value disagrees with the
  // accepted level; any return to agreement restarts the stability window.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = stable;
  assign rise = accept & sync2;
`else
  assign dout = sync2;
  // sync2 takes sync1 on the next edge, so this predicts its 0->1 change.
  assign rise = sync1 & ~sync2;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral on the core data bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   addr       : byte address; hit when addr[31:6] == BASE_ADDR[31:6]
//   wdata      : write data
//   wstrb      : byte enables; only full-word writes take effect
//   rdata      : registered read data (one-cycle latency), 0 on a miss
//   gpio_in    : asynchronous board inputs
//   gpio_out   : output register (the OUT flops themselves)
//   irq        : level interrupt, |(EDGE & IRQ_EN)
// Register window: IN(0x00) OUT(0x04) OUT_SET(0x08) OUT_CLR(0x0C)
//                  EDGE(0x10, W1C) IRQ_EN(0x14).
// Optional feature macro: MMIO_GPIO_DEBOUNCE_EN enables per-input debounce.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int          DATA_WIDTH      = 32,
  parameter int          N_IN            = 8,
  parameter int          N_OUT           = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int          DEBOUNCE_CYCLES = 125000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic [N_IN-1:0]         gpio_in,
  output logic [N_OUT-1:0]        gpio_out,
  output logic                    irq
);

  localparam int WIN_LSB = $clog2(GPIO_WINDOW_BYTES);
  localparam int STRB_W  = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mmio_gpio: DATA_WIDTH must be 32");
  end
  if (N_IN < 1 || N_IN > 32 || N_OUT < 1 || N_OUT > 32) begin : g_bad_count
    $error("mmio_gpio: N_IN and N_OUT must be within 1..32");
  end

  logic [N_IN-1:0]       in_lvl;
  logic [N_IN-1:0]       in_rise;
  logic [N_OUT-1:0]      out_q;
  logic [N_IN-1:0]       edge_flags;
  logic [N_IN-1:0]       irq_en_q;
  logic                  hit;
  logic                  wr;
  logic [5:0]            ofs;
  logic [N_IN-1:0]       w1c;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  unused_bits;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (gpio_in[i]),
      .dout  (in_lvl[i]),
      .rise  (in_rise[i])
    );
  end

  assign hit = (addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign ofs = {addr[5:2], 2'b00};
  assign wr  = hit && (wstrb == {STRB_W{1'b1}});
  assign w1c = (wr && ofs == GPIO_EDGE_OFS) ? wdata[N_IN-1:0] : '0;

  // Byte lanes and write-data bits beyond the implemented channels are
  // intentionally ignored.
  assign unused_bits = ^{addr[1:0], wdata};

  // Read mux sees register state before any write on the same edge.
  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (ofs)
        GPIO_IN_OFS:     rd_next = DATA_WIDTH'(in_lvl);
        GPIO_OUT_OFS:    rd_next = DATA_WIDTH'(out_q);
        GPIO_EDGE_OFS:   rd_next = DATA_WIDTH'(edge_flags);
        GPIO_IRQ_EN_OFS: rd_next = DATA_WIDTH'(irq_en_q);
        default:         rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      edge_flags <= '0;
      irq_en_q   <= '0;
      rdata      <= '0;
    end else begin
      if (wr && ofs == GPIO_OUT_OFS) begin
        out_q <= wdata[N_OUT-1:0];
      end else if (wr && ofs == GPIO_OUT_SET_OFS) begin
        out_q <= out_q | wdata[N_OUT-1:0];
      end else if (wr && ofs == GPIO_OUT_CLR_OFS) begin
        out_q <= out_q & ~wdata[N_OUT-1:0];
      end
      if (wr && ofs == GPIO_IRQ_EN_OFS) begin
        irq_en_q <= wdata[N_IN-1:0];
      end
      // A fresh rising edge wins over a clear of the same bit.
      edge_flags <= (edge_flags & ~w1c) | in_rise;
      rdata      <= rd_next;
    end
  end

  assign gpio_out = out_q;
  assign irq      = |(edge_flags & irq_en_q);

endmodule
